// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) for the
// seven-segment display path; outputs update atomically when a conversion ends.
module bin_to_bcd_converter #(
    parameter int WIDTH      = 32,
    parameter int DIGITS     = 8,
    parameter int INT_DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      number,
    input  logic                  refresh,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int ACC_W = 4 * INT_DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   last_number;
    logic [WIDTH-1:0]   shift_reg;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt;
    logic               load, shift_en, finish;
    logic [DIGITS-1:0]  mask_next;
    logic               ovf_next;

    function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Bit i is set when digit i is at or below the most-significant nonzero digit.
    function automatic logic [DIGITS-1:0] lead_mask(input logic [4*DIGITS-1:0] d);
        logic [DIGITS-1:0] m;
        logic              seen;
        m    = '0;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen = seen | (d[4*i +: 4] != 4'd0);
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    assign acc_adj   = add3_digits(acc);
    assign mask_next = lead_mask(acc[4*DIGITS-1:0]);

    generate
        if (INT_DIGITS > DIGITS) begin : g_ovf
            assign ovf_next = |acc[ACC_W-1:4*DIGITS];
        end else begin : g_no_ovf
            assign ovf_next = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if ((number != last_number) || refresh) begin
                    load       = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1))
                    state_next = S_DONE;
            end
            S_DONE: begin
                finish     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs only change on the finish cycle, so the display never sees partial sums.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_number <= '0;
            shift_reg   <= '0;
            acc         <= '0;
            cnt         <= '0;
            bcd         <= '0;
            digit_valid <= DIGITS'(1);
            overflow    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                shift_reg   <= number;
                last_number <= number;
                acc         <= '0;
                cnt         <= '0;
                busy        <= 1'b1;
            end
            if (shift_en) begin
                acc       <= {acc_adj[ACC_W-2:0], shift_reg[WIDTH-1]};
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                cnt       <= cnt + CNT_W'(1);
            end
            if (finish) begin
                bcd         <= acc[4*DIGITS-1:0];
                digit_valid <= mask_next;
                overflow    <= ovf_next;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Scoreboard bench for bin_to_bcd_converter: expectations are queued when a
// conversion is requested and compared when done pulses.
module tb_bin_to_bcd_converter;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 8;
    localparam int LAT_NEG = WIDTH + 2;  // negedges from drive to visible done

    logic                clk = 1'b0;
    logic                reset;
    logic [WIDTH-1:0]    number;
    logic                refresh;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   digit_valid;
    logic                overflow, busy, done;

    typedef struct packed {
        logic [4*DIGITS-1:0] bcd;
        logic [DIGITS-1:0]   dv;
        logic                ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;

    bin_to_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS), .INT_DIGITS(10)) dut (
        .clk(clk), .reset(reset), .number(number), .refresh(refresh),
        .bcd(bcd), .digit_valid(digit_valid), .overflow(overflow),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    function automatic exp_t model(input logic [WIDTH-1:0] v);
        exp_t        e;
        logic [63:0] x;
        int          hi;
        x  = 64'(v);
        hi = 0;
        for (int i = 0; i < DIGITS; i++) begin
            e.bcd[4*i +: 4] = 4'(x % 10);
            if ((x % 10) != 0) hi = i;
            x = x / 10;
        end
        e.ovf = (x != 0);
        for (int i = 0; i < DIGITS; i++) e.dv[i] = (i <= hi);
        return e;
    endfunction

    task automatic push(input logic [WIDTH-1:0] v);
        sb.push_back(model(v));
    endtask

    // Waits for done; at cycle poke_at either pulses refresh or changes number.
    task automatic wait_done(input int poke_at, input logic poke_refresh,
                             input logic [WIDTH-1:0] poke_num,
                             output int cyc, output logic busy_first,
                             output logic bcd_changed);
        logic [4*DIGITS-1:0] start_bcd;
        start_bcd   = bcd;
        cyc         = -1;
        busy_first  = 1'b0;
        bcd_changed = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            refresh = 1'b0;
            if (c == poke_at) begin
                if (poke_refresh) refresh = 1'b1;
                else              number  = poke_num;
            end
            if (c == 1) busy_first = busy;
            if (done) begin
                cyc = c;
                break;
            end
            if (bcd !== start_bcd) bcd_changed = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; number = '0; refresh = 1'b0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (bcd !== 32'h0) begin errors++; $display("FAIL reset_bcd got=%h exp=%h", bcd, 32'h0); end
        if (digit_valid !== 8'h01) begin errors++; $display("FAIL reset_dv got=%h exp=01", digit_valid); end
        if (overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ovf=%b busy=%b done=%b exp=000", overflow, busy, done);
        end
        reset = 1'b0;
        repeat (50) @(negedge clk);
        checks += 3;
        if (busy_cnt != 0) begin errors++; $display("FAIL idle_busy got=%0d exp=0", busy_cnt); end
        if (done_cnt != 0) begin errors++; $display("FAIL idle_done got=%0d exp=0", done_cnt); end
        if (bcd !== 32'h0 || digit_valid !== 8'h01 || overflow !== 1'b0) begin
            errors++; $display("FAIL idle_outputs got=%h/%h/%b exp=00000000/01/0", bcd, digit_valid, overflow);
        end
    endtask

    task automatic test_latency;
        int   cyc;
        logic bf, chg;
        exp_t e;
        number = 32'd12345678;
        push(number);
        wait_done(0, 1'b0, '0, cyc, bf, chg);
        checks += 3;
        if (bf !== 1'b1) begin errors++; $display("FAIL lat_busy got=%b exp=1", bf); end
        if (cyc != LAT_NEG) begin errors++; $display("FAIL lat_cycles got=%0d exp=%0d", cyc, LAT_NEG); end
        if (chg !== 1'b0) begin errors++; $display("FAIL lat_stable got=%b exp=0", chg); end
        if (cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks += 3;
            if (bcd !== e.bcd) begin errors++; $display("FAIL lat_bcd got=%h exp=%h", bcd, e.bcd); end
            if (digit_valid !== e.dv) begin errors++; $display("FAIL lat_dv got=%h exp=%h", digit_valid, e.dv); end
            if (overflow !== e.ovf) begin errors++; $display("FAIL lat_ovf got=%b exp=%b", overflow, e.ovf); end
        end
    endtask

    task automatic test_values;
        logic [WIDTH-1:0] vals [2];
        int   cyc;
        logic bf, chg;
        exp_t e;
        vals[0] = 32'd100;
        vals[1] = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            number = vals[k];
            push(number);
            wait_done(0, 1'b0, '0, cyc, bf, chg);
            checks++;
            if (cyc < 0 || sb.size() == 0) begin
                errors++; $display("FAIL val%0d_done got=timeout exp=done", k);
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (bcd !== e.bcd) begin errors++; $display("FAIL val%0d_bcd got=%h exp=%h", k, bcd, e.bcd); end
                if (digit_valid !== e.dv) begin errors++; $display("FAIL val%0d_dv got=%h exp=%h", k, digit_valid, e.dv); end
                if (overflow !== e.ovf) begin errors++; $display("FAIL val%0d_ovf got=%b exp=%b", k, overflow, e.ovf); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int   cyc, snap;
        logic bf, chg;
        exp_t e;
        @(negedge clk);
        snap   = done_cnt;
        number = 32'd5;
        push(32'd5);
        push(32'd7);
        wait_done(10, 1'b0, 32'd7, cyc, bf, chg);
        checks += 2;
        if (cyc != LAT_NEG) begin errors++; $display("FAIL b2b_first_cycles got=%0d exp=%0d", cyc, LAT_NEG); end
        if (chg !== 1'b0) begin errors++; $display("FAIL b2b_stable got=%b exp=0", chg); end
        if (cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bcd !== e.bcd) begin errors++; $display("FAIL b2b_first_bcd got=%h exp=%h", bcd, e.bcd); end
        end
        wait_done(0, 1'b0, '0, cyc, bf, chg);
        checks += 2;
        if (bf !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b exp=1", bf); end
        if (cyc != LAT_NEG) begin errors++; $display("FAIL b2b_second_cycles got=%0d exp=%0d", cyc, LAT_NEG); end
        if (cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks += 2;
            if (bcd !== e.bcd) begin errors++; $display("FAIL b2b_second_bcd got=%h exp=%h", bcd, e.bcd); end
            if (digit_valid !== e.dv) begin errors++; $display("FAIL b2b_second_dv got=%h exp=%h", digit_valid, e.dv); end
        end
        repeat (50) @(negedge clk);
        checks++;
        if (done_cnt - snap != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", done_cnt - snap); end
    endtask

    task automatic test_refresh;
        int   cyc, snap;
        logic bf, chg;
        exp_t e;
        number = 32'd42;
        push(32'd42);
        wait_done(0, 1'b0, '0, cyc, bf, chg);
        if (cyc > 0 && sb.size() > 0) e = sb.pop_front();
        checks++;
        if (bcd !== 32'h42) begin errors++; $display("FAIL ref_initial got=%h exp=%h", bcd, 32'h42); end
        @(negedge clk);
        snap    = done_cnt;
        refresh = 1'b1;
        push(32'd42);
        wait_done(10, 1'b1, '0, cyc, bf, chg);
        checks += 2;
        if (bf !== 1'b1) begin errors++; $display("FAIL ref_busy got=%b exp=1", bf); end
        if (cyc != LAT_NEG) begin errors++; $display("FAIL ref_cycles got=%0d exp=%0d", cyc, LAT_NEG); end
        if (cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bcd !== e.bcd) begin errors++; $display("FAIL ref_bcd got=%h exp=%h", bcd, e.bcd); end
        end
        repeat (50) @(negedge clk);
        checks++;
        if (done_cnt - snap != 1) begin errors++; $display("FAIL ref_pulses got=%0d exp=1", done_cnt - snap); end
    endtask

    task automatic test_reset_mid;
        int   cyc, snap;
        logic bf, chg;
        exp_t e;
        @(negedge clk);
        snap   = done_cnt;
        number = 32'd999;
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks += 3;
        if (bcd !== 32'h0) begin errors++; $display("FAIL rmid_bcd got=%h exp=%h", bcd, 32'h0); end
        if (digit_valid !== 8'h01) begin errors++; $display("FAIL rmid_dv got=%h exp=01", digit_valid); end
        if (busy !== 1'b0 || overflow !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rmid_flags got busy=%b ovf=%b done=%b exp=000", busy, overflow, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (done_cnt != snap) begin errors++; $display("FAIL rmid_no_done got=%0d exp=%0d", done_cnt - snap, 0); end
        push(32'd999);
        wait_done(0, 1'b0, '0, cyc, bf, chg);
        checks++;
        if (cyc != LAT_NEG) begin errors++; $display("FAIL rmid_cycles got=%0d exp=%0d", cyc, LAT_NEG); end
        if (cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks += 2;
            if (bcd !== e.bcd) begin errors++; $display("FAIL rmid_bcd_after got=%h exp=%h", bcd, e.bcd); end
            if (digit_valid !== e.dv) begin errors++; $display("FAIL rmid_dv_after got=%h exp=%h", digit_valid, e.dv); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_values();
        test_back_to_back();
        test_refresh();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits between the processor's display word output and the seven-segment display subsystem, so the display shows decimal instead of hex.
- Re-converts automatically whenever the input word changes. Also supports a forced refresh.
- Outputs the packed BCD digits, a leading-digit mask for blanking, and an overflow flag.

Parameters:
- WIDTH, 32, binary input width.
- DIGITS, 8, number of BCD digits output (one per display digit).
- INT_DIGITS, 10, internal accumulator digits; must satisfy 10^INT_DIGITS > 2^WIDTH − 1.

Ports:
- clk  input  1  system clock (25 MHz domain).
- reset  input  1  asynchronous, active-high reset.
- number  input  WIDTH  binary value to convert.
- refresh  input  1  single-cycle pulse; forces a conversion even if number is unchanged.
- bcd  output  4*DIGITS  packed BCD result; digit 0 is in [3:0].
- digit_valid  output  DIGITS  bit i=1 if digit i is at or below the most-significant nonzero digit; bit 0 is always 1.
- overflow  output  1  value ≥ 10^DIGITS; bcd then holds value mod 10^DIGITS.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when bcd, digit_valid and overflow update.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; bcd=0, digit_valid=1 (only bit 0 set), overflow=0, busy=0, done=0.
  - last_number=0, shift counter=0, accumulator=0.
  - Reset values are consistent with a converted input of 0.
- State machine IDLE → SHIFT → DONE → IDLE.
- IDLE:
  - Trigger = (number != last_number) OR refresh.
  - On a trigger edge E0: load number into the shift register and last_number; clear the accumulator and counter; busy=1; go to SHIFT.
- SHIFT, one edge per bit, WIDTH edges total:
  - In each INT_DIGITS digit, add 3 to any digit ≥ 5.
  - Then shift {accumulator, shift register} left by 1, MSB first.
  - The counter increments each edge; after the WIDTH-th shift (edge E0+WIDTH), go to DONE.
- DONE (edge E0+WIDTH+1):
  - Register bcd = low DIGITS digits and overflow = (any digit above DIGITS is nonzero).
  - Register digit_valid from the low DIGITS digits.
  - done=1 for exactly this cycle; busy=0; go to IDLE.
- Latency: results are visible WIDTH+1 cycles after the sampling edge (33 cycles at default).
- Outputs hold their previous values throughout a conversion and update atomically only at DONE. The display never sees partial results.
- Changes to number or refresh during SHIFT or DONE are ignored. Back in IDLE, the comparison against last_number restarts conversion on the next edge, so the final value is always converted.
- A refresh pulse arriving while busy is dropped.
- Reset mid-conversion aborts immediately; all outputs return to reset values.
- Minimum period between conversions: WIDTH+2 cycles.

Test Plan:
- Reset, hold number=0 for 50 cycles → bcd=0, digit_valid=8'h01, overflow=0, busy never asserts, done never pulses.
- number=32'd12345678 → busy rises after 1 edge; done pulses exactly 33 cycles after the sampling edge; bcd=32'h12345678, digit_valid=8'hFF, overflow=0.
- number=32'd100 → bcd=32'h00000100, digit_valid=8'b00000111, overflow=0. Then number=32'hFFFFFFFF → bcd=32'h94967295, overflow=1, digit_valid=8'hFF.
- number=5, then number=7 ten cycles after conversion starts:
  - first done gives bcd=5 while bcd is stable during SHIFT;
  - the next conversion starts 1 cycle after done;
  - second done gives bcd=7;
  - exactly two done pulses.
- Hold number=42 after conversion, pulse refresh → one extra conversion, done pulses, bcd stays 32'h00000042. A refresh pulsed while busy causes no further conversion.
- Start a conversion of 999, assert reset at cycle 15 (asynchronously, mid-cycle):
  - outputs clear immediately with no done;
  - after release with number still 999, a new conversion starts and yields bcd=32'h00000999.
